obi_sram_pipelined: RTL

- OBI subordinate wrapping a single-port tc_sram with configurable read latency and response backpressure (rready).
- An out-of-range address is answered with an error response instead of silently aliasing into memory.
- Tracks up to RespDepth outstanding transactions and buffers responses, so a stalled manager never loses read data.
- Drop-in successor for the zero-wait SRAM subordinates on the zeroHETI interconnect; rvalid timing stays identical when rready is held high and Latency=1.

---
 rtl/obi_sram_pipelined_if.sv | 29 ++
 rtl/obi_sram_pipelined.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_pipelined_if.sv
// OBI subordinate port bundle for obi_sram_pipelined: request channel plus
// response channel with backpressure.
interface obi_sram_pipelined_if #(
    parameter int DataWidth = 32
);
    // Request: transfer when req && gnt at a rising edge; the manager holds the
    // request fields stable until granted. Response: transfer when
    // rvalid && rready; rvalid, rdata and err stay stable until taken.
    logic                   req;
    logic                   gnt;
    logic [31:0]            addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic                   rvalid;
    logic                   rready;
    logic [DataWidth-1:0]   rdata;
    logic                   err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/obi_sram_pipelined.sv
// OBI subordinate over a single-port SRAM with configurable read latency,
// out-of-range error responses and a response FIFO that absorbs rready stalls.

module tc_sram #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 32,
    parameter int Latency   = 1,
    localparam int AddrWidth = $clog2(NumWords),
    localparam int BeWidth   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic [DataWidth-1:0] rdata_o
);
    logic [DataWidth-1:0] mem_q   [NumWords];
    logic [DataWidth-1:0] rdata_q [Latency];

    // Storage has no reset: contents survive a reset of the subordinate.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (req_i && !we_i) rdata_q[0] <= mem_q[addr_i];
        for (int s = 1; s < Latency; s++) rdata_q[s] <= rdata_q[s-1];
    end

    assign rdata_o = rdata_q[Latency-1];
endmodule

module obi_sram_pipelined #(
    parameter int          NumWords  = 1024,
    parameter int          DataWidth = 32,
    parameter logic [31:0] BaseAddr  = 32'h0,
    parameter int          Latency   = 1,
    parameter int          RespDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    obi_sram_pipelined_if.slave  sbr
);
    localparam int BeWidth   = DataWidth / 8;
    localparam int AddrWidth = $clog2(NumWords);
    localparam int ByteBits  = $clog2(BeWidth);
    localparam int MemBytes  = NumWords * BeWidth;
    localparam int CntWidth  = $clog2(RespDepth + 1);
    localparam int PtrWidth  = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    logic [31:0]          off;
    logic                 in_range;
    logic                 gnt;
    logic                 hs;
    logic                 sram_req;
    logic [DataWidth-1:0] sram_rdata;

    logic [CntWidth-1:0]  outstanding_q, outstanding_d;
    logic [Latency-1:0]   pipe_valid_q, pipe_valid_d;
    logic [Latency-1:0]   pipe_err_q, pipe_err_d;
    logic [Latency-1:0]   pipe_we_q, pipe_we_d;

    logic [DataWidth-1:0] fifo_data_q [RespDepth];
    logic [DataWidth-1:0] fifo_data_d [RespDepth];
    logic [RespDepth-1:0] fifo_err_q, fifo_err_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  fifo_cnt_q, fifo_cnt_d;

    logic                 exit_valid;
    logic                 exit_err;
    logic [DataWidth-1:0] exit_rdata;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 rvalid;
    logic                 pop;
    logic                 fifo_pop;
    logic                 push;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RespDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Offset wraps modulo 2^32, so addresses below BaseAddr land far out of range.
    assign off      = sbr.addr - BaseAddr;
    assign in_range = ({1'b0, off} < 33'(MemBytes));
    assign gnt      = sbr.req && !rst_i && (outstanding_q < CntWidth'(RespDepth));
    assign hs       = sbr.req && gnt;
    assign sram_req = hs && in_range;

    tc_sram #(
        .NumWords  (NumWords),
        .DataWidth (DataWidth),
        .Latency   (Latency)
    ) u_sram (
        .clk_i   (clk_i),
        .req_i   (sram_req),
        .we_i    (sbr.we),
        .addr_i  (off[AddrWidth+ByteBits-1:ByteBits]),
        .wdata_i (sbr.wdata),
        .be_i    (sbr.be),
        .rdata_o (sram_rdata)
    );

    assign exit_valid = pipe_valid_q[Latency-1];
    assign exit_err   = exit_valid && pipe_err_q[Latency-1];
    assign exit_rdata = (exit_valid && !pipe_err_q[Latency-1] && !pipe_we_q[Latency-1])
                        ? sram_rdata : '0;

    // An empty FIFO is bypassed so an unstalled response costs no extra cycle.
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CntWidth'(RespDepth));
    assign rvalid     = !fifo_empty || exit_valid;
    assign pop        = rvalid && sbr.rready;
    assign fifo_pop   = pop && !fifo_empty;
    assign push       = exit_valid && !(fifo_empty && pop);

    assign sbr.gnt    = gnt;
    assign sbr.rvalid = rvalid;
    assign sbr.rdata  = fifo_empty ? exit_rdata : fifo_data_q[rd_ptr_q];
    assign sbr.err    = fifo_empty ? exit_err : fifo_err_q[rd_ptr_q];

    always_comb begin
        outstanding_d = outstanding_q;
        if (hs && !pop)      outstanding_d = outstanding_q + 1'b1;
        else if (!hs && pop) outstanding_d = outstanding_q - 1'b1;
    end

    always_comb begin
        pipe_valid_d    = pipe_valid_q;
        pipe_err_d      = pipe_err_q;
        pipe_we_d       = pipe_we_q;
        pipe_valid_d[0] = hs;
        pipe_err_d[0]   = !in_range;
        pipe_we_d[0]    = sbr.we;
        for (int s = 1; s < Latency; s++) begin
            pipe_valid_d[s] = pipe_valid_q[s-1];
            pipe_err_d[s]   = pipe_err_q[s-1];
            pipe_we_d[s]    = pipe_we_q[s-1];
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_err_d  = fifo_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = exit_rdata;
            fifo_err_d[wr_ptr_q]  = exit_err;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!push && fifo_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            pipe_valid_q  <= '0;
            pipe_err_q    <= '0;
            pipe_we_q     <= '0;
            fifo_data_q   <= '{default: '0};
            fifo_err_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_err_q    <= pipe_err_d;
            pipe_we_q     <= pipe_we_d;
            fifo_data_q   <= fifo_data_d;
            fifo_err_q    <= fifo_err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // The outstanding limit bounds every response, so the FIFO can never overflow.
    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));
    outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
                                        outstanding_q <= CntWidth'(RespDepth));
endmodule
